sprite_commit_ctrl: RTL

//   Frame-synchronous commit scheduler for the sprite object table. Owns the staging table written
//   by the TinyQV host, and copies it byte-serially into the renderer's active table on the vsync

---
 rtl/sprite_commit_ctrl_pkg.sv | 24 ++
 rtl/sprite_stage_ram.sv | 29 ++
 rtl/sprite_commit_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sprite_commit_ctrl_pkg.sv
// Sprite commit controller shared definitions.
// Table geometry, FSM encoding and object byte layout.
package sprite_commit_ctrl_pkg;

  localparam int DEF_N_SPRITES = 4;
  localparam int DEF_OBJ_BYTES = 4;
  localparam int DEF_AW        = 4;

  localparam int OFS_X    = 0;
  localparam int OFS_Y    = 1;
  localparam int OFS_TILE = 2;
  localparam int OFS_ATTR = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COPY  = 2'd2
  } state_e;

  function automatic int tbl_size(input int n, input int b);
    return n * b;
  endfunction

endpackage

// File: rtl/sprite_stage_ram.sv
// Staging table: TBL x 8 register file.
// One sync write port, one async read port, cleared on reset.
module sprite_stage_ram #(
  parameter int TBL = 16,
  parameter int AW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [TBL];

  // byte write, whole table cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TBL; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sprite_commit_ctrl.sv
// Frame-synchronous sprite table commit scheduler.
// Copies staging bytes into the active table on vsync.
module sprite_commit_ctrl
  import sprite_commit_ctrl_pkg::*;
#(
  parameter int N_SPRITES = DEF_N_SPRITES,
  parameter int OBJ_BYTES = DEF_OBJ_BYTES,
  parameter int AW        = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [7:0]    host_wr_data,
  output logic          host_wr_ready,
  input  logic          commit_arm,
  output logic          act_we,
  output logic [AW-1:0] act_waddr,
  output logic [7:0]    act_wdata,
  output logic          armed,
  output logic          busy,
  output logic          commit_done,
  output logic          frame_irq,
  output logic          overrun,
  output logic [7:0]    commit_cnt
);

  localparam int TBL = tbl_size(N_SPRITES, OBJ_BYTES);
  localparam logic [AW-1:0] LAST = AW'(TBL - 1);
  localparam logic [AW:0]   TBLW = (AW + 1)'(TBL);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q;
  logic          vsync_d_q;
  logic          arm_pend_q;
  logic          irq_q;
  logic          done_q;
  logic          ovr_q;
  logic [7:0]    cnt_q;

  logic          edge_w;
  logic          is_copy;
  logic          copy_last;
  logic          wr_ok;
  logic [7:0]    rdata;

  assign edge_w    = vsync & ~vsync_d_q;
  assign is_copy   = (state_q == ST_COPY);
  assign copy_last = is_copy && (idx_q == LAST);
  assign wr_ok     = host_wr_en & host_wr_ready
                   & ({1'b0, host_wr_addr} < TBLW);

  sprite_stage_ram #(
    .TBL (TBL),
    .AW  (AW)
  ) u_stage (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_ok),
    .waddr_i (host_wr_addr),
    .wdata_i (host_wr_data),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (commit_arm) state_d = ST_ARMED;
      ST_ARMED: if (edge_w) state_d = ST_COPY;
      ST_COPY: begin
        if (copy_last)
          state_d = (arm_pend_q | commit_arm) ? ST_ARMED : ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // copy index, edge history, pulses and sticky counters
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      vsync_d_q  <= 1'b1;
      arm_pend_q <= 1'b0;
      irq_q      <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      vsync_d_q <= vsync;
      irq_q     <= edge_w & (state_q == ST_IDLE);
      done_q    <= copy_last;
      if (copy_last) cnt_q <= cnt_q + 8'd1;
      if (edge_w & is_copy) ovr_q <= 1'b1;
      if (is_copy && !copy_last) begin
        idx_q      <= idx_q + 1'b1;
        arm_pend_q <= arm_pend_q | commit_arm;
      end else begin
        idx_q      <= '0;
        arm_pend_q <= 1'b0;
      end
    end
  end

  // outputs; act_we is masked by reset so an aborted copy stops at once
  always_comb begin
    act_we        = is_copy & ~reset;
    act_waddr     = idx_q;
    act_wdata     = rdata;
    armed         = (state_q == ST_ARMED);
    busy          = is_copy;
    host_wr_ready = ~is_copy;
    commit_done   = done_q;
    frame_irq     = irq_q;
    overrun       = ovr_q;
    commit_cnt    = cnt_q;
  end

endmodule
